branch_target_predictor: RTL and testbench
==========================================

Name: branch_target_predictor

Overview:
- Direct-mapped branch target buffer (BTB) with 2-bit saturating counters.
- Produces the prediction-enable and predicted-address inputs for the next-PC calculation stage.
- Fetch looks up the current PC combinationally.
- The execute/branch-resolution stage writes back the actual outcome one update per cycle, which trains the table.

Parameters:
- XLEN, 32: address width.
- INDEX_BITS, 4: table index width; ENTRIES = 2**INDEX_BITS (default 16).
- TAG_BITS, XLEN-INDEX_BITS-2: derived, not overridden.

Ports:
- clk_in  input  1  clock; all state updates on rising edge.
- rst_in  input  1  reset; asynchronous, active-high.
- btp_pc_in  input  XLEN  fetch PC to look up.
- btp_pred_en_out  output  1  predict taken; drives the next-PC prediction enable.
- btp_pred_addr_out  output  XLEN  predicted target; drives the next-PC prediction address.
- btp_upd_valid_in  input  1  resolved-branch update strobe.
- btp_upd_pc_in  input  XLEN  PC of the resolved branch.
- btp_upd_taken_in  input  1  actual outcome, 1 = taken.
- btp_upd_target_in  input  XLEN  actual target of the resolved branch.
- btp_flush_in  input  1  synchronous invalidate of all entries.
- btp_miss_count_out  output  32  misprediction count (see Optional Feature).

Behaviour:
- Per-entry state: valid (1), tag (TAG_BITS), target (XLEN), ctr (2).
- Address split: idx = pc[INDEX_BITS+1:2]; tag = pc[XLEN-1:INDEX_BITS+2]; pc[1:0] ignored.
- Lookup, combinational, zero latency:
  - hit = valid[idx] && tag[idx]==tag(btp_pc_in).
  - btp_pred_en_out = hit && ctr[idx][1].
  - btp_pred_addr_out = target[idx] when btp_pred_en_out=1, else 0.
- Update, registered, when btp_upd_valid_in=1, using uidx/utag from btp_upd_pc_in:
  - Tag hit, taken: ctr saturating increment (3 stays 3); target <= btp_upd_target_in.
  - Tag hit, not taken: ctr saturating decrement (0 stays 0); target unchanged.
  - Miss, taken: allocate/replace the entry. valid<=1, tag<=utag, target<=btp_upd_target_in, ctr<=2'b10 (weakly taken).
  - Miss, not taken: no state change.
- Read/write ordering:
  - A lookup and an update to the same index in the same cycle: the lookup returns pre-update state.
  - The new state is visible from the next cycle.
- Flush:
  - btp_flush_in=1 clears all valid bits at the next edge; tags, targets and counters are left untouched.
  - Flush together with an update in the same cycle: flush wins and the update is discarded, including its allocation.
  - Flush has no effect on btp_miss_count_out.
- Reset:
  - Asserting rst_in asynchronously clears all valid bits, sets all ctr to 2'b01, and zeroes btp_miss_count_out.
  - Therefore btp_pred_en_out=0 and btp_pred_addr_out=0 immediately on reset assertion.
  - Reset asserted mid-update aborts that update; no partial entry write is allowed.
- Implementation: one write port, one read port; register-based table, no memory macro required.

Optional Feature:
- Macro: BTP_MISS_COUNTER_EN.
- Defined: a 32-bit counter increments on each accepted (non-flushed) update whose stored prediction was wrong.
  - Stored prediction = utag hit && ctr[1], evaluated before the update is applied.
  - Wrong means: the stored prediction differs from btp_upd_taken_in, or it predicted taken but target != btp_upd_target_in.
  - The counter wraps from 0xFFFFFFFF to 0.
- Not defined: btp_miss_count_out is tied to 0 and no counter logic is generated.

Test Plan:
- Reset, then lookup PC 0x00000040 -> btp_pred_en_out=0, btp_pred_addr_out=0.
- Update pc=0x40, taken=1, target=0x100 -> next cycle, lookup 0x40 gives pred_en=1, addr=0x100 (ctr=2).
- Two not-taken updates to 0x40 after allocation -> ctr goes 2->1->0; lookup gives pred_en=0. Three taken updates then saturate ctr at 3; a fourth keeps pred_en=1.
- Aliasing: allocate 0x40, then taken update pc=0x440 (same idx 0, different tag), target=0x200 -> lookup 0x40 gives pred_en=0; lookup 0x440 gives addr=0x200.
- Same-cycle update and flush: flush=1 with taken update for 0x80 -> next cycle, lookups of 0x40 and 0x80 both give pred_en=0.
- With BTP_MISS_COUNTER_EN: taken update 0x40 from reset counts +1 (predicted not-taken); a second identical update counts +0. A taken update with target 0x104 counts +1, so total = 2. Assert rst_in mid-sequence -> count=0 immediately.

Source files
------------

// File: rtl/branch_target_predictor.sv
`default_nettype none
//==============================================================================
// Module      : branch_target_predictor
// Description : Direct-mapped branch target buffer with 2-bit saturating
//               counters. Fetch looks up btp_pc_in combinationally; the
//               branch-resolution stage trains the table with one update per
//               cycle. The table is register based (one read, one write port).
//
// Ports       : clk_in             - clock, rising edge
//               rst_in             - asynchronous active-high reset
//               btp_pc_in          - fetch PC to look up
//               btp_pred_en_out    - predict taken (next-PC prediction enable)
//               btp_pred_addr_out  - predicted target (0 when not predicting)
//               btp_upd_valid_in   - resolved-branch update strobe
//               btp_upd_pc_in      - PC of the resolved branch
//               btp_upd_taken_in   - actual outcome, 1 = taken
//               btp_upd_target_in  - actual target of the resolved branch
//               btp_flush_in       - synchronous invalidate of all entries
//               btp_miss_count_out - misprediction count (0 when disabled)
//
// Options     : BTP_MISS_COUNTER_EN - when defined, a wrapping 32-bit counter
//               of mispredicted accepted updates drives btp_miss_count_out.
//
// Revision    : 1.0 - initial release
//==============================================================================
module branch_target_predictor #(
    parameter int XLEN       = 32,
    parameter int INDEX_BITS = 4
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic [XLEN-1:0] btp_pc_in,
    output logic            btp_pred_en_out,
    output logic [XLEN-1:0] btp_pred_addr_out,
    input  logic            btp_upd_valid_in,
    input  logic [XLEN-1:0] btp_upd_pc_in,
    input  logic            btp_upd_taken_in,
    input  logic [XLEN-1:0] btp_upd_target_in,
    input  logic            btp_flush_in,
    output logic [31:0]     btp_miss_count_out
);

    localparam int TAG_BITS = XLEN - INDEX_BITS - 2;
    localparam int ENTRIES  = 2 ** INDEX_BITS;

    localparam logic [1:0] C_CTR_RESET = 2'b01;
    localparam logic [1:0] C_CTR_ALLOC = 2'b10;
    localparam logic [1:0] C_CTR_MAX   = 2'b11;
    localparam logic [1:0] C_CTR_MIN   = 2'b00;

    // Table state
    logic [ENTRIES-1:0]  r_valid;
    logic [TAG_BITS-1:0] r_tag    [ENTRIES];
    logic [XLEN-1:0]     r_target [ENTRIES];
    logic [1:0]          r_ctr    [ENTRIES];

    // Lookup path
    logic [INDEX_BITS-1:0] w_lk_idx;
    logic [TAG_BITS-1:0]   w_lk_tag;
    logic                  w_lk_hit;

    // Update path
    logic [INDEX_BITS-1:0] w_up_idx;
    logic [TAG_BITS-1:0]   w_up_tag;
    logic                  w_up_hit;
    logic [1:0]            w_up_ctr;
    logic [1:0]            w_up_ctr_next;

    // Byte-offset bits never take part in indexing or tagging.
    logic w_unused_bits;
    assign w_unused_bits = ^{btp_pc_in[1:0], btp_upd_pc_in[1:0]};

    //--------------------------------------------------------------------------
    // Lookup: purely combinational, sees pre-update state in the same cycle.
    //--------------------------------------------------------------------------
    assign w_lk_idx = btp_pc_in[INDEX_BITS+1:2];
    assign w_lk_tag = btp_pc_in[XLEN-1:INDEX_BITS+2];
    assign w_lk_hit = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);

    assign btp_pred_en_out   = w_lk_hit && r_ctr[w_lk_idx][1];
    assign btp_pred_addr_out = btp_pred_en_out ? r_target[w_lk_idx] : '0;

    //--------------------------------------------------------------------------
    // Update decode
    //--------------------------------------------------------------------------
    assign w_up_idx = btp_upd_pc_in[INDEX_BITS+1:2];
    assign w_up_tag = btp_upd_pc_in[XLEN-1:INDEX_BITS+2];
    assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);
    assign w_up_ctr = r_ctr[w_up_idx];

    // Saturating counter step in the direction of the resolved outcome.
    always_comb begin
        w_up_ctr_next = w_up_ctr;
        if (btp_upd_taken_in) begin
            if (w_up_ctr != C_CTR_MAX) begin
                w_up_ctr_next = w_up_ctr + 2'b01;
            end
        end else begin
            if (w_up_ctr != C_CTR_MIN) begin
                w_up_ctr_next = w_up_ctr - 2'b01;
            end
        end
    end

    //--------------------------------------------------------------------------
    // Table write. Reset is asynchronous so an update in flight when reset
    // rises is simply never written. Flush only drops valid bits and takes
    // priority over a same-cycle update (including an allocation).
    //--------------------------------------------------------------------------
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_valid <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_ctr[i]    <= C_CTR_RESET;
            end
        end else if (btp_flush_in) begin
            r_valid <= '0;
        end else if (btp_upd_valid_in) begin
            if (w_up_hit) begin
                r_ctr[w_up_idx] <= w_up_ctr_next;
                if (btp_upd_taken_in) begin
                    r_target[w_up_idx] <= btp_upd_target_in;
                end
            end else if (btp_upd_taken_in) begin
                // Allocate or replace the aliased entry, starting weakly taken.
                r_valid[w_up_idx]  <= 1'b1;
                r_tag[w_up_idx]    <= w_up_tag;
                r_target[w_up_idx] <= btp_upd_target_in;
                r_ctr[w_up_idx]    <= C_CTR_ALLOC;
            end
        end
    end

    //--------------------------------------------------------------------------
    // Misprediction counter
    //--------------------------------------------------------------------------
`ifdef BTP_MISS_COUNTER_EN
    logic [31:0] r_miss_count;
    logic        w_up_pred;
    logic        w_up_wrong;

    // The stored prediction is what the table would have said before this
    // update is applied.
    assign w_up_pred  = w_up_hit && w_up_ctr[1];
    assign w_up_wrong = (w_up_pred != btp_upd_taken_in) ||
                        (w_up_pred && (r_target[w_up_idx] != btp_upd_target_in));

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_miss_count <= '0;
        end else if (btp_upd_valid_in && !btp_flush_in && w_up_wrong) begin
            r_miss_count <= r_miss_count + 32'd1;
        end
    end

    assign btp_miss_count_out = r_miss_count;
`else
    assign btp_miss_count_out = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_target_predictor.sv
`default_nettype none
//==============================================================================
// Module      : tb_branch_target_predictor
// Description : Self-checking bench for branch_target_predictor. A directed
//               vector table, hand-written reset/miss-counter sequences and a
//               randomized phase checked against a behavioural table model.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_branch_target_predictor;

    localparam int XLEN    = 32;
    localparam int ENTRIES = 16;

    logic            clk_in = 1'b0;
    logic            rst_in = 1'b1;
    logic [XLEN-1:0] btp_pc_in = '0;
    logic            btp_pred_en_out;
    logic [XLEN-1:0] btp_pred_addr_out;
    logic            btp_upd_valid_in = 1'b0;
    logic [XLEN-1:0] btp_upd_pc_in = '0;
    logic            btp_upd_taken_in = 1'b0;
    logic [XLEN-1:0] btp_upd_target_in = '0;
    logic            btp_flush_in = 1'b0;
    logic [31:0]     btp_miss_count_out;

    branch_target_predictor #(.XLEN(XLEN), .INDEX_BITS(4)) dut (
        .clk_in             (clk_in),
        .rst_in             (rst_in),
        .btp_pc_in          (btp_pc_in),
        .btp_pred_en_out    (btp_pred_en_out),
        .btp_pred_addr_out  (btp_pred_addr_out),
        .btp_upd_valid_in   (btp_upd_valid_in),
        .btp_upd_pc_in      (btp_upd_pc_in),
        .btp_upd_taken_in   (btp_upd_taken_in),
        .btp_upd_target_in  (btp_upd_target_in),
        .btp_flush_in       (btp_flush_in),
        .btp_miss_count_out (btp_miss_count_out)
    );

    always #5 clk_in = ~clk_in;

    int n_tests = 0;
    int n_fail  = 0;

    //--------------------------------------------------------------------------
    // Behavioural model: a table of entries indexed by (pc/4) mod 16, tagged
    // by pc/64, each with a counter value 0..3.
    //--------------------------------------------------------------------------
    bit          m_valid  [ENTRIES];
    int unsigned m_tag    [ENTRIES];
    int unsigned m_target [ENTRIES];
    int          m_ctr    [ENTRIES];
    int unsigned m_miss;

    function automatic void model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i]   = 1;
        end
        m_miss = 0;
    endfunction

    function automatic bit model_hit(input int unsigned pc);
        int i;
        i = (pc / 4) % ENTRIES;
        return m_valid[i] && (m_tag[i] == pc / 64);
    endfunction

    function automatic bit model_en(input int unsigned pc);
        return model_hit(pc) && (m_ctr[(pc / 4) % ENTRIES] >= 2);
    endfunction

    function automatic int unsigned model_addr(input int unsigned pc);
        return model_en(pc) ? m_target[(pc / 4) % ENTRIES] : 0;
    endfunction

    function automatic void model_update(input bit v, input int unsigned pc,
                                         input bit tk, input int unsigned tgt,
                                         input bit fl);
        int i;
        bit hit;
        bit pred;
        i = (pc / 4) % ENTRIES;
        if (fl) begin
            for (int k = 0; k < ENTRIES; k++) m_valid[k] = 1'b0;
            return;
        end
        if (!v) return;
        hit  = model_hit(pc);
        pred = model_en(pc);
`ifdef BTP_MISS_COUNTER_EN
        if ((pred != tk) || (pred && m_target[i] != tgt)) m_miss = m_miss + 1;
`endif
        if (hit) begin
            if (tk) begin
                m_ctr[i]    = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
                m_target[i] = tgt;
            end else begin
                m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
            end
        end else if (tk) begin
            m_valid[i]  = 1'b1;
            m_tag[i]    = pc / 64;
            m_target[i] = tgt;
            m_ctr[i]    = 2;
        end
    endfunction

    //--------------------------------------------------------------------------
    // Helpers
    //--------------------------------------------------------------------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic drive(input bit v, input logic [31:0] upc, input bit tk,
                         input logic [31:0] tgt, input bit fl, input logic [31:0] lpc);
        btp_upd_valid_in  = v;
        btp_upd_pc_in     = upc;
        btp_upd_taken_in  = tk;
        btp_upd_target_in = tgt;
        btp_flush_in      = fl;
        btp_pc_in         = lpc;
    endtask

    // Clock edge: the model absorbs the inputs held across the edge.
    task automatic tick();
        @(posedge clk_in);
        model_update(btp_upd_valid_in, btp_upd_pc_in, btp_upd_taken_in,
                     btp_upd_target_in, btp_flush_in);
        #1;
    endtask

    task automatic check_model(input string nm);
        chk({nm, " en"},    {31'd0, btp_pred_en_out}, {31'd0, model_en(btp_pc_in)});
        chk({nm, " addr"},  btp_pred_addr_out,        model_addr(btp_pc_in));
        chk({nm, " count"}, btp_miss_count_out,       m_miss);
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 32'h40);
        rst_in = 1'b1;
        model_reset();
        #1;
        @(posedge clk_in);
        #2;
        rst_in = 1'b0;
        @(posedge clk_in);
        #1;
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] p;
        p = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
        return p;
    endfunction

    //--------------------------------------------------------------------------
    // Directed vectors: each row is applied for one cycle; expected lookup
    // values refer to the state before that row's update takes effect.
    //--------------------------------------------------------------------------
    typedef struct {
        bit          uv;
        logic [31:0] upc;
        bit          utk;
        logic [31:0] utgt;
        bit          fl;
        logic [31:0] lpc;
        bit          een;
        logic [31:0] eaddr;
    } vec_t;

    vec_t vt [18];

    initial begin
        logic [31:0] upc;
        logic [31:0] tgt;
        logic [31:0] tsel [4];

        vt[0]  = '{0, 32'h000, 0, 32'h000, 0, 32'h040, 0, 32'h000}; // reset state
        vt[1]  = '{1, 32'h040, 1, 32'h100, 0, 32'h040, 0, 32'h000}; // allocate, pre-update read
        vt[2]  = '{1, 32'h040, 0, 32'h000, 0, 32'h040, 1, 32'h100}; // ctr 2 -> 1
        vt[3]  = '{1, 32'h040, 0, 32'h000, 0, 32'h040, 0, 32'h000}; // ctr 1 -> 0
        vt[4]  = '{1, 32'h040, 0, 32'h000, 0, 32'h040, 0, 32'h000}; // 0 stays 0
        vt[5]  = '{1, 32'h040, 1, 32'h100, 0, 32'h040, 0, 32'h000}; // 0 -> 1
        vt[6]  = '{1, 32'h040, 1, 32'h100, 0, 32'h040, 0, 32'h000}; // 1 -> 2
        vt[7]  = '{1, 32'h040, 1, 32'h100, 0, 32'h040, 1, 32'h100}; // 2 -> 3
        vt[8]  = '{1, 32'h040, 1, 32'h108, 0, 32'h040, 1, 32'h100}; // 3 stays 3, new target
        vt[9]  = '{1, 32'h040, 0, 32'h000, 0, 32'h043, 1, 32'h108}; // low bits ignored; 3 -> 2
        vt[10] = '{1, 32'h040, 0, 32'h000, 0, 32'h040, 1, 32'h108}; // 2 -> 1
        vt[11] = '{1, 32'h040, 1, 32'h108, 0, 32'h040, 0, 32'h000}; // 1 -> 2
        vt[12] = '{1, 32'h440, 1, 32'h200, 0, 32'h040, 1, 32'h108}; // alias replaces idx 0
        vt[13] = '{0, 32'h000, 0, 32'h000, 0, 32'h040, 0, 32'h000}; // old tag gone
        vt[14] = '{1, 32'h080, 1, 32'h300, 1, 32'h440, 1, 32'h200}; // flush + update
        vt[15] = '{0, 32'h000, 0, 32'h000, 0, 32'h080, 0, 32'h000}; // allocation discarded
        vt[16] = '{0, 32'h000, 0, 32'h000, 0, 32'h440, 0, 32'h000}; // flushed
        vt[17] = '{0, 32'h000, 0, 32'h000, 0, 32'h040, 0, 32'h000};

        // Reset asserted at time 0: outputs must already be quiet.
        model_reset();
        #2;
        chk("reset en",    {31'd0, btp_pred_en_out}, 32'd0);
        chk("reset addr",  btp_pred_addr_out,        32'd0);
        chk("reset count", btp_miss_count_out,       32'd0);
        do_reset();

        // Directed table
        for (int i = 0; i < 18; i++) begin
            drive(vt[i].uv, vt[i].upc, vt[i].utk, vt[i].utgt, vt[i].fl, vt[i].lpc);
            #1;
            chk($sformatf("vec%0d en", i),    {31'd0, btp_pred_en_out}, {31'd0, vt[i].een});
            chk($sformatf("vec%0d addr", i),  btp_pred_addr_out,        vt[i].eaddr);
            chk($sformatf("vec%0d count", i), btp_miss_count_out,       m_miss);
            tick();
        end

        // Reset rising mid-cycle with an update pending: outputs clear at once
        // and the update is never written.
        do_reset();
        drive(1, 32'h40, 1, 32'h100, 0, 32'h40);
        tick();
        drive(1, 32'h40, 1, 32'h500, 0, 32'h40);
        #1;
        chk("pre-reset en", {31'd0, btp_pred_en_out}, 32'd1);
        rst_in = 1'b1;
        model_reset();
        #1;
        chk("async reset en",    {31'd0, btp_pred_en_out}, 32'd0);
        chk("async reset addr",  btp_pred_addr_out,        32'd0);
        chk("async reset count", btp_miss_count_out,       32'd0);
        @(posedge clk_in);
        #2;
        rst_in = 1'b0;
        drive(0, 0, 0, 0, 0, 32'h40);
        #1;
        chk("aborted update en", {31'd0, btp_pred_en_out}, 32'd0);
        @(posedge clk_in);
        #1;

`ifdef BTP_MISS_COUNTER_EN
        do_reset();
        drive(1, 32'h40, 1, 32'h100, 0, 32'h40);
        tick();
        chk("miss first alloc", btp_miss_count_out, 32'd1);
        tick();
        chk("miss correct",     btp_miss_count_out, 32'd1);
        drive(1, 32'h40, 1, 32'h104, 0, 32'h40);
        tick();
        chk("miss target",      btp_miss_count_out, 32'd2);
        drive(1, 32'h40, 0, 32'h0, 1, 32'h40);
        tick();
        chk("miss flushed",     btp_miss_count_out, 32'd2);
        drive(0, 0, 0, 0, 0, 32'h40);
        #1;
        rst_in = 1'b1;
        model_reset();
        #1;
        chk("miss reset",       btp_miss_count_out, 32'd0);
        @(posedge clk_in);
        #2;
        rst_in = 1'b0;
        @(posedge clk_in);
        #1;
`endif

        // Randomized phase against the model
        do_reset();
        tsel[0] = 32'h100;
        tsel[1] = 32'h104;
        tsel[2] = 32'h200;
        for (int c = 0; c < 600; c++) begin
            tsel[3] = $urandom;
            upc = rand_pc();
            tgt = tsel[$urandom_range(0, 3)];
            drive(($urandom % 4) != 0, upc, $urandom_range(0, 1) == 1, tgt,
                  ($urandom % 32) == 0,
                  ($urandom % 4 == 0) ? upc : rand_pc());
            #1;
            check_model($sformatf("rand%0d", c));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
